// File: rtl/prime_search.sv
// rtl/prime_search.sv - probable-prime search controller driving a miller_rabin enable/done handshake.
// Optional mod-15 trial-division pre-filter enabled by defining PRIME_SEARCH_TRIAL_DIV_EN.
module prime_search #(
    parameter int WORD_WIDTH = 32,
    parameter int MAX_TRIES  = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WORD_WIDTH-1:0] seed,
    input  logic [5:0]            security_parameter_in,
    output logic                  busy,
    output logic                  done,
    output logic                  found,
    output logic [WORD_WIDTH-1:0] prime,
    output logic [15:0]           attempts,
    output logic                  mr_enable,
    output logic [WORD_WIDTH-1:0] mr_n,
    output logic [5:0]            mr_security_parameter,
    input  logic                  mr_done,
    input  logic                  mr_is_prime
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_LOAD      = 3'd1;
    localparam logic [2:0] S_ISSUE     = 3'd2;
    localparam logic [2:0] S_WAIT_CLR  = 3'd3;
    localparam logic [2:0] S_WAIT_DONE = 3'd4;
    localparam logic [2:0] S_NEXT      = 3'd5;
    localparam logic [2:0] S_FINISH    = 3'd6;

    localparam logic [WORD_WIDTH-1:0] TOP_BIT   = {1'b1, {(WORD_WIDTH-1){1'b0}}};
    localparam logic [WORD_WIDTH-1:0] LOW_BIT   = {{(WORD_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WORD_WIDTH-1:0] WRAP_CAND = TOP_BIT | LOW_BIT;
    localparam logic [15:0]           MAX_TRIES_W = 16'(MAX_TRIES);

    logic [2:0]            state_q, state_d;
    logic [WORD_WIDTH-1:0] cand_q, cand_d;
    logic [5:0]            sec_q, sec_d;
    logic [15:0]           attempts_q, attempts_d;
    logic                  found_q, found_d;
    logic [WORD_WIDTH-1:0] prime_q, prime_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  mr_enable_q, mr_enable_d;
    logic [WORD_WIDTH:0]   cand_sum;

`ifdef PRIME_SEARCH_TRIAL_DIV_EN
    localparam int IDX_W = $clog2(WORD_WIDTH);

    logic [3:0]       r15_q, r15_d;
    logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
    logic             full_q, full_d;
    logic [4:0]       r_shift;
    logic [3:0]       r_serial;
    logic [3:0]       r_load;
    logic [4:0]       r_plus2;

    // Candidate shares a factor with 15 exactly when its residue does.
    function automatic logic has_small_factor(input logic [3:0] r);
        return (r == 4'd0) || (r == 4'd3) || (r == 4'd5) || (r == 4'd6) ||
               (r == 4'd9) || (r == 4'd10) || (r == 4'd12);
    endfunction
`endif

    assign cand_sum = {1'b0, cand_q} + {{(WORD_WIDTH-1){1'b0}}, 2'd2};

    always_comb begin
        state_d    = state_q;
        cand_d     = cand_q;
        sec_d      = sec_q;
        attempts_d = attempts_q;
        found_d    = found_q;
        prime_d    = prime_q;
`ifdef PRIME_SEARCH_TRIAL_DIV_EN
        r15_d     = r15_q;
        bit_idx_d = bit_idx_q;
        full_d    = full_q;
        r_shift   = {r15_q, cand_q[bit_idx_q]};
        r_serial  = (r_shift >= 5'd15) ? 4'(r_shift - 5'd15) : r_shift[3:0];
        r_load    = full_q ? r_serial : r15_q;
        r_plus2   = {1'b0, r15_q} + 5'd2;
`endif

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cand_d     = seed | TOP_BIT | LOW_BIT;
                    sec_d      = security_parameter_in;
                    attempts_d = '0;
                    found_d    = 1'b0;
                    prime_d    = '0;
                    state_d    = S_LOAD;
`ifdef PRIME_SEARCH_TRIAL_DIV_EN
                    full_d    = 1'b1;
                    bit_idx_d = IDX_W'(WORD_WIDTH - 1);
                    r15_d     = '0;
`endif
                end
            end
            S_LOAD: begin
`ifdef PRIME_SEARCH_TRIAL_DIV_EN
                // Full residue is rebuilt MSB-first only after start or a wrap.
                if (full_q) begin
                    r15_d = r_serial;
                    if (bit_idx_q != '0) begin
                        bit_idx_d = bit_idx_q - 1'b1;
                    end else begin
                        full_d  = 1'b0;
                        state_d = has_small_factor(r_load) ? S_NEXT : S_ISSUE;
                    end
                end else begin
                    state_d = has_small_factor(r_load) ? S_NEXT : S_ISSUE;
                end
`else
                state_d = S_ISSUE;
`endif
            end
            S_ISSUE: begin
                attempts_d = attempts_q + 16'd1;
                state_d    = S_WAIT_CLR;
            end
            S_WAIT_CLR: begin
                if (!mr_done) begin
                    state_d = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (mr_done) begin
                    if (mr_is_prime) begin
                        found_d = 1'b1;
                        prime_d = cand_q;
                        state_d = S_FINISH;
                    end else if (attempts_q >= MAX_TRIES_W) begin
                        state_d = S_FINISH;
                    end else begin
                        state_d = S_NEXT;
                    end
                end
            end
            S_NEXT: begin
                if (cand_sum[WORD_WIDTH] || !cand_sum[WORD_WIDTH-1]) begin
                    cand_d = WRAP_CAND;
`ifdef PRIME_SEARCH_TRIAL_DIV_EN
                    full_d    = 1'b1;
                    bit_idx_d = IDX_W'(WORD_WIDTH - 1);
                    r15_d     = '0;
`endif
                end else begin
                    cand_d = cand_sum[WORD_WIDTH-1:0];
`ifdef PRIME_SEARCH_TRIAL_DIV_EN
                    r15_d = (r_plus2 >= 5'd15) ? 4'(r_plus2 - 5'd15) : r_plus2[3:0];
`endif
                end
                state_d = S_LOAD;
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are registered from the next state so each lines up with its state's cycle.
        busy_d      = (state_d != S_IDLE) && (state_d != S_FINISH);
        done_d      = (state_d == S_FINISH);
        mr_enable_d = (state_d == S_ISSUE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cand_q      <= '0;
            sec_q       <= '0;
            attempts_q  <= '0;
            found_q     <= 1'b0;
            prime_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            mr_enable_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cand_q      <= cand_d;
            sec_q       <= sec_d;
            attempts_q  <= attempts_d;
            found_q     <= found_d;
            prime_q     <= prime_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            mr_enable_q <= mr_enable_d;
        end
    end

`ifdef PRIME_SEARCH_TRIAL_DIV_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r15_q     <= '0;
            bit_idx_q <= '0;
            full_q    <= 1'b0;
        end else begin
            r15_q     <= r15_d;
            bit_idx_q <= bit_idx_d;
            full_q    <= full_d;
        end
    end
`endif

    assign busy                  = busy_q;
    assign done                  = done_q;
    assign found                 = found_q;
    assign prime                 = prime_q;
    assign attempts              = attempts_q;
    assign mr_enable             = mr_enable_q;
    assign mr_n                  = cand_q;
    assign mr_security_parameter = sec_q;

endmodule

// File: tb/tb_prime_search.sv
// tb/tb_prime_search.sv - directed table-driven bench for prime_search with a behavioural miller_rabin.
module tb_prime_search;

    logic       clk;
    logic       rst;
    int         checks;
    int         errors;

    logic       start_a, start_b;
    logic [7:0] seed_a, seed_b;
    logic       busy_a, done_a, found_a, en_a, mrd_a, isp_a;
    logic       busy_b, done_b, found_b, en_b, mrd_b, isp_b;
    logic [7:0] prime_a, n_a, prime_b, n_b;
    logic [15:0] att_a, att_b;
    logic [5:0] sec_out_a, sec_out_b;
    int         cnt_a, cnt_b;
    int         n_iss_a, n_iss_b;
    int         iss_a [0:255];

    prime_search #(.WORD_WIDTH(8), .MAX_TRIES(1024)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .seed(seed_a), .security_parameter_in(6'd2),
        .busy(busy_a), .done(done_a), .found(found_a), .prime(prime_a), .attempts(att_a),
        .mr_enable(en_a), .mr_n(n_a), .mr_security_parameter(sec_out_a),
        .mr_done(mrd_a), .mr_is_prime(isp_a));

    prime_search #(.WORD_WIDTH(8), .MAX_TRIES(1)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .seed(seed_b), .security_parameter_in(6'd2),
        .busy(busy_b), .done(done_b), .found(found_b), .prime(prime_b), .attempts(att_b),
        .mr_enable(en_b), .mr_n(n_b), .mr_security_parameter(sec_out_b),
        .mr_done(mrd_b), .mr_is_prime(isp_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit is_prime8(input int n);
        if (n < 2) return 1'b0;
        for (int d = 2; d * d <= n; d++) begin
            if (n % d == 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Level done that stays stale for one cycle after enable, then drops, then rises with the verdict.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mrd_a <= 1'b0; isp_a <= 1'b0; cnt_a <= 0;
        end else if (en_a) begin
            cnt_a <= 5;
        end else if (cnt_a != 0) begin
            cnt_a <= cnt_a - 1;
            if (cnt_a == 4) mrd_a <= 1'b0;
            if (cnt_a == 1) begin mrd_a <= 1'b1; isp_a <= is_prime8(int'(n_a)); end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mrd_b <= 1'b0; isp_b <= 1'b0; cnt_b <= 0;
        end else if (en_b) begin
            cnt_b <= 5;
        end else if (cnt_b != 0) begin
            cnt_b <= cnt_b - 1;
            if (cnt_b == 4) mrd_b <= 1'b0;
            if (cnt_b == 1) begin mrd_b <= 1'b1; isp_b <= is_prime8(int'(n_b)); end
        end
    end

    initial begin
        n_iss_a = 0;
        n_iss_b = 0;
    end
    always @(posedge clk) begin
        if (en_a) begin
            if (n_iss_a < 256) iss_a[n_iss_a] = int'(n_a);
            n_iss_a = n_iss_a + 1;
        end
        if (en_b) n_iss_b = n_iss_b + 1;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_done_a(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (done_a) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        check({name, "_timeout"}, int'(seen), 1);
    endtask

    task automatic run_a(input logic [7:0] s, input string name);
        @(negedge clk);
        seed_a  = s;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        wait_done_a(name);
    endtask

    task automatic wait_issue_a();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (en_a) break;
        end
    endtask

    typedef struct {
        logic [7:0] seed;
        int         exp_found;
        int         exp_prime;
        int         exp_att;
    } vec_t;

    vec_t vecs [5];
    int   base;
    int   expa_00;
    int   expa_fe;

    initial begin
        checks  = 0;
        errors  = 0;
        rst     = 1'b0;
        start_a = 1'b0; start_b = 1'b0;
        seed_a  = '0;   seed_b  = '0;
`ifdef PRIME_SEARCH_TRIAL_DIV_EN
        expa_00 = 1; expa_fe = 1;
`else
        expa_00 = 2; expa_fe = 3;
`endif
        vecs[0] = '{8'h16, 1, 151, 1};
        vecs[1] = '{8'h00, 1, 131, expa_00};
        vecs[2] = '{8'hFE, 1, 131, expa_fe};
        vecs[3] = '{8'h7A, 1, 251, 1};
        vecs[4] = '{8'hB4, 1, 181, 1};

        repeat (3) @(negedge clk);
        check("rst_busy", int'(busy_a), 0);
        check("rst_done", int'(done_a), 0);
        check("rst_mr_n", int'(n_a), 0);
        rst = 1'b1;
        @(negedge clk);

        // Start latency: busy and mr_enable both high after the second edge.
        seed_a  = 8'h16;
        start_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_a = 1'b0;
        @(posedge clk);
        #1;
        check("lat_busy", int'(busy_a), 1);
`ifndef PRIME_SEARCH_TRIAL_DIV_EN
        check("lat_mr_enable", int'(en_a), 1);
        check("lat_mr_n", int'(n_a), 151);
`endif
        check("lat_sec", int'(sec_out_a), 2);
        @(negedge clk);
        wait_done_a("lat");
        check("lat_prime", int'(prime_a), 151);
        @(negedge clk);
        check("done_one_cycle", int'(done_a), 0);

        for (int v = 0; v < 5; v++) begin
            base = n_iss_a;
            run_a(vecs[v].seed, $sformatf("vec%0d", v));
            check($sformatf("vec%0d_found", v), int'(found_a), vecs[v].exp_found);
            check($sformatf("vec%0d_prime", v), int'(prime_a), vecs[v].exp_prime);
            check($sformatf("vec%0d_attempts", v), int'(att_a), vecs[v].exp_att);
            check($sformatf("vec%0d_busy_fin", v), int'(busy_a), 0);
            check($sformatf("vec%0d_issued", v), n_iss_a - base, vecs[v].exp_att);
            check($sformatf("vec%0d_last_n", v), iss_a[(n_iss_a - 1) % 256], vecs[v].exp_prime);
`ifndef PRIME_SEARCH_TRIAL_DIV_EN
            if (vecs[v].seed == 8'hFE) begin
                check("wrap_seq0", iss_a[base % 256], 255);
                check("wrap_seq1", iss_a[(base + 1) % 256], 129);
                check("wrap_seq2", iss_a[(base + 2) % 256], 131);
            end
`endif
        end

        // Start during FINISH is ignored, accepted on the following cycle.
        run_a(8'hB4, "fin");
        seed_a  = 8'h16;
        start_a = 1'b1;
        @(negedge clk);
        check("fin_start_ignored", int'(busy_a), 0);
        check("fin_hold_prime", int'(prime_a), 181);
        @(negedge clk);
        start_a = 1'b0;
        check("fin_start_next", int'(busy_a), 1);
        wait_done_a("fin2");
        check("fin2_prime", int'(prime_a), 151);

        // Start pulse while waiting on miller_rabin must not disturb the search.
        @(negedge clk);
        seed_a  = 8'h00;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        wait_issue_a();
        repeat (3) @(negedge clk);
        seed_a  = 8'h16;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        wait_done_a("restart");
        check("restart_prime", int'(prime_a), 131);
        check("restart_attempts", int'(att_a), expa_00);

        // Asynchronous reset mid-wait clears every output at once.
        @(negedge clk);
        seed_a  = 8'h00;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        wait_issue_a();
        repeat (3) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("arst_busy", int'(busy_a), 0);
        check("arst_found", int'(found_a), 0);
        check("arst_attempts", int'(att_a), 0);
        check("arst_mr_n", int'(n_a), 0);
        check("arst_sec", int'(sec_out_a), 0);
        check("arst_mr_enable", int'(en_a), 0);
        @(negedge clk);
        rst = 1'b1;
        run_a(8'h16, "post_rst");
        check("post_rst_prime", int'(prime_a), 151);
        check("post_rst_found", int'(found_a), 1);

        // Budget of one: the rejected 129 ends the search unsuccessfully.
        base = n_iss_b;
        @(negedge clk);
        seed_b  = 8'h00;
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 3000; i++) begin
                if (done_b) begin seen = 1'b1; break; end
                @(negedge clk);
            end
            check("max1_timeout", int'(seen), 1);
        end
`ifndef PRIME_SEARCH_TRIAL_DIV_EN
        check("max1_found", int'(found_b), 0);
        check("max1_prime", int'(prime_b), 0);
`else
        check("max1_found", int'(found_b), 1);
        check("max1_prime", int'(prime_b), 131);
`endif
        check("max1_attempts", int'(att_b), 1);
        check("max1_issued", n_iss_b - base, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/prime_search.md
# prime_search

Key-generation front end that finds a WORD_WIDTH-bit probable prime for the RSA datapath. It forms an odd, top-bit-set candidate from a seed and issues it to a miller_rabin instance through that block's enable/done interface. On rejection it steps the candidate by 2 and retries, until a candidate is accepted or the attempt budget is spent. It is the initiator side of the miller_rabin handshake and sits between the seed source and the key-assembly logic.

## Interface
- WORD_WIDTH, 32, candidate width in bits; must be ≥ 4.
- MAX_TRIES, 1024, maximum miller_rabin invocations per search; 1..65535.

- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  begin a search; sampled only in IDLE.
- seed  in  WORD_WIDTH  initial candidate bits.
- security_parameter_in  in  6  Miller-Rabin round count; latched at start.
- busy  out  1  search in progress.
- done  out  1  one-cycle pulse at search end.
- found  out  1  1 = prime holds an accepted candidate.
- prime  out  WORD_WIDTH  accepted candidate; 0 if not found.
- attempts  out  16  miller_rabin invocations used in the last search.
- mr_enable  out  1  one-cycle start pulse to miller_rabin.
- mr_n  out  WORD_WIDTH  candidate under test.
- mr_security_parameter  out  6  latched round count.
- mr_done  in  1  miller_rabin completion (level).
- mr_is_prime  in  1  miller_rabin verdict, valid while mr_done=1.

## Operation
- States: IDLE, LOAD, ISSUE, WAIT_CLR, WAIT_DONE, NEXT, FINISH.
- **IDLE, start=1:**
  - cand = seed | 2^(WORD_WIDTH-1) | 1.
  - Latch security_parameter_in.
  - Clear attempts, found and prime.
  - Go to LOAD.
- **LOAD:** go to ISSUE; see Configuration for the variant.
- **ISSUE:**
  - mr_enable=1 for exactly this cycle.
  - attempts += 1.
  - Go to WAIT_CLR.
- **WAIT_CLR:** wait until mr_done is sampled 0, which discards a stale done from the previous test. Then go to WAIT_DONE.
- **WAIT_DONE:** wait for mr_done=1.
  - If mr_is_prime=1: found=1, prime=cand, go to FINISH.
  - Else if attempts == MAX_TRIES: go to FINISH with found=0.
  - Else: go to NEXT.
- **NEXT:**
  - cand += 2, modulo 2^WORD_WIDTH.
  - On wrap, or when the result has the top bit clear, cand = 2^(WORD_WIDTH-1)+1.
  - Go to LOAD.
- **FINISH:**
  - done=1 and busy=0 in this cycle.
  - Return to IDLE.
- mr_n = cand, held stable from ISSUE until WAIT_DONE exits.
- mr_security_parameter holds the latched value.
- busy=1 in every state except IDLE and FINISH.
- start outside IDLE is ignored.
- found, prime and attempts hold from FINISH until the next accepted start.
- attempts never exceeds MAX_TRIES.

## Timing
- Reset (rst=0, asynchronous): state=IDLE; all outputs 0; internal candidate, residue and latches cleared.
- Reset mid-search takes effect immediately:
  - mr_enable drops without completing its pulse.
  - The miller_rabin instance is reset externally from the same rst.
- **Start latency:**
  - start is sampled at edge k.
  - busy=1 after edge k+1.
  - mr_enable is high during cycle k+2 (without macro).
- Per rejected candidate, controller overhead is 4 cycles plus miller_rabin latency (ISSUE, WAIT_CLR ≥1, NEXT, LOAD).
- The done pulse follows the accepting mr_done sample by one cycle.
- start asserted in the same cycle as FINISH is ignored; it is accepted the next cycle.

## Configuration
- **PRIME_SEARCH_TRIAL_DIV_EN defined:**
  - LOAD computes r15 = cand mod 15 bit-serially, MSB first: r = (2r + b) mod 15, over WORD_WIDTH cycles.
  - This happens only after start or after a wrap.
  - Otherwise NEXT updates r15 = (r15 + 2) mod 15 and LOAD takes 1 cycle.
  - If r15 mod 3 == 0 or r15 mod 5 == 0, LOAD goes to NEXT instead of ISSUE. Skipped candidates do not increment attempts.
- **Undefined:** no residue logic; LOAD is always 1 cycle; every candidate is issued.

## Test plan
All scenarios use WORD_WIDTH=8 and a miller_rabin instance with security_parameter_in=2.

- Seed 0x16, no macro -> candidate 151 issued; done pulse with found=1, prime=151, attempts=1.
- Seed 0x00, no macro -> 129 issued and rejected, then 131 issued; prime=131, attempts=2.
  - Same with PRIME_SEARCH_TRIAL_DIV_EN -> 129 skipped without an mr_enable pulse; prime=131, attempts=1.
- Seed 0xFE, no macro -> candidates 255, 129, 131 in order (wrap from 255 to 129); prime=131, attempts=3.
  - Same with the macro -> attempts=1.
- MAX_TRIES=1, seed 0x00, no macro -> one mr_enable pulse; done with found=0, prime=0, attempts=1.
- start pulsed again during WAIT_DONE -> ignored; results match the single-start run.
- rst driven low during WAIT_DONE -> all outputs 0 immediately. After release, start with seed 0x16 yields prime=151.
